decode_byte_window: RTL and testbench

//  Instruction byte window sitting in front of the decode command logic. Accepts

---
 rtl/decode_byte_window_if.sv | 27 ++
 rtl/decode_byte_window.sv | 68 ++++++
 tb/tb_decode_byte_window.sv | 118 +++++++++++
 3 files changed

// File: rtl/decode_byte_window_if.sv
// decode_byte_window_if: fetch, consume and window signals of the decode byte window.
// Stats ports exist only when DECODE_WINDOW_STATS_EN is defined.
interface decode_byte_window_if #(parameter int WINDOW_BYTES = 12);
  logic                      dec_flush;
  logic                      fetch_valid;
  logic [31:0]               fetch_data;
  logic [2:0]                fetch_count;
  logic                      fetch_accept;
  logic                      consume_valid;
  logic [3:0]                consume_len;
  logic                      consume_err;
  logic [8*WINDOW_BYTES-1:0] decoder;
  logic [3:0]                decoder_count;
`ifdef DECODE_WINDOW_STATS_EN
  logic [31:0]               stat_bytes_consumed;
  logic [31:0]               stat_starve_cycles;
  modport master (output dec_flush, fetch_valid, fetch_data, fetch_count, consume_valid, consume_len,
                  input fetch_accept, consume_err, decoder, decoder_count, stat_bytes_consumed, stat_starve_cycles);
  modport slave (input dec_flush, fetch_valid, fetch_data, fetch_count, consume_valid, consume_len,
                 output fetch_accept, consume_err, decoder, decoder_count, stat_bytes_consumed, stat_starve_cycles);
`else
  modport master (output dec_flush, fetch_valid, fetch_data, fetch_count, consume_valid, consume_len,
                  input fetch_accept, consume_err, decoder, decoder_count);
  modport slave (input dec_flush, fetch_valid, fetch_data, fetch_count, consume_valid, consume_len,
                 output fetch_accept, consume_err, decoder, decoder_count);
`endif
endinterface

// File: rtl/decode_byte_window.sv
// decode_byte_window: byte window feeding decode; oldest byte at decoder[7:0].
// Optional counters enabled by defining DECODE_WINDOW_STATS_EN.
module decode_byte_window #(
  parameter int WINDOW_BYTES = 12,
  parameter int FETCH_BYTES  = 4
) (
  input logic clk,
  input logic rst_n,
  decode_byte_window_if.slave bus
);
  localparam int WB = 8*WINDOW_BYTES;
  logic [3:0]    count_q, count_d;
  logic [WB-1:0] data_q, data_d;
  logic          err_q, err_d;
  logic          consume_ok, fetch_ok;
  logic [4:0]    cons, add, base, cnt_new;
  logic [WB-1:0] shifted, fetch_ext, keep_m, new_m;
  assign bus.fetch_accept  = (5'(count_q) <= 5'(WINDOW_BYTES-FETCH_BYTES)) && !bus.dec_flush;
  assign bus.decoder       = data_q;
  assign bus.decoder_count = count_q;
  assign bus.consume_err   = err_q;
  // Consume-then-append: surviving bytes shift down, new bytes land right above them.
  always_comb begin
    keep_m = '0;
    new_m = '0;
    consume_ok = bus.consume_valid && bus.consume_len != 4'd0 && bus.consume_len <= count_q;
    fetch_ok = bus.fetch_valid && bus.fetch_accept && bus.fetch_count != 3'd0 &&
               5'(bus.fetch_count) <= 5'(FETCH_BYTES);
    cons = consume_ok ? 5'(bus.consume_len) : 5'd0;
    add = fetch_ok ? 5'(bus.fetch_count) : 5'd0;
    base = 5'(count_q) - cons;
    cnt_new = base + add;
    shifted = data_q >> {cons, 3'b000};
    fetch_ext = WB'(bus.fetch_data) << {base, 3'b000};
    for (int i = 0; i < WINDOW_BYTES; i++) begin
      keep_m[8*i +: 8] = {8{5'(i) < base}};
      new_m[8*i +: 8] = {8{5'(i) < cnt_new}};
    end
    count_d = bus.dec_flush ? 4'd0 : cnt_new[3:0];
    data_d = bus.dec_flush ? '0 : (shifted & keep_m) | (fetch_ext & new_m & ~keep_m);
    err_d = !bus.dec_flush && bus.consume_valid && !consume_ok;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      data_q <= '0;
      err_q <= 1'b0;
    end else begin
      count_q <= count_d;
      data_q <= data_d;
      err_q <= err_d;
    end
  end
`ifdef DECODE_WINDOW_STATS_EN
  logic [31:0] consumed_q, starve_q;
  assign bus.stat_bytes_consumed = consumed_q;
  assign bus.stat_starve_cycles  = starve_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      consumed_q <= '0;
      starve_q <= '0;
    end else if (!bus.dec_flush) begin
      consumed_q <= consumed_q + 32'(cons);
      starve_q <= starve_q + 32'(count_q == 4'd0);
    end
  end
`endif
endmodule

// File: tb/tb_decode_byte_window.sv
// tb_decode_byte_window: directed stimulus with a queued scoreboard checked by a negedge monitor.
module tb_decode_byte_window;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  decode_byte_window_if bus();
  decode_byte_window dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  typedef struct {
    int          cyc;
    string       name;
    logic [3:0]  cnt;
    logic [95:0] dec;
    logic        acc;
    logic        err;
  } exp_t;
  exp_t q[$];
  int cyc = 0;
  int checks = 0;
  int errors = 0;
  always @(posedge clk) cyc <= cyc + 1;
  function automatic void chk(string name, logic [95:0] act, logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction
  // Monitor: state seen while a step's inputs are applied, compared mid-cycle.
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc == cyc) begin
      exp_t e;
      e = q.pop_front();
      chk({e.name, " count"}, 96'(bus.decoder_count), 96'(e.cnt));
      chk({e.name, " decoder"}, bus.decoder, e.dec);
      chk({e.name, " accept"}, 96'(bus.fetch_accept), 96'(e.acc));
      chk({e.name, " err"}, 96'(bus.consume_err), 96'(e.err));
    end
  end
  task automatic step(input bit fv, input logic [31:0] fd, input logic [2:0] fc,
                      input bit cv, input logic [3:0] cl, input bit fl);
    @(posedge clk);
    #1;
    bus.fetch_valid = fv;
    bus.fetch_data = fd;
    bus.fetch_count = fc;
    bus.consume_valid = cv;
    bus.consume_len = cl;
    bus.dec_flush = fl;
  endtask
  task automatic expect_st(input string n, input logic [3:0] c, input logic [95:0] d,
                           input logic a, input logic e);
    q.push_back('{cyc, n, c, d, a, e});
  endtask
  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end
  initial begin
`ifdef DECODE_WINDOW_STATS_EN
    logic [31:0] s;
`endif
    bus.fetch_valid = 0; bus.fetch_data = 0; bus.fetch_count = 0;
    bus.consume_valid = 0; bus.consume_len = 0; bus.dec_flush = 0;
    repeat (2) @(negedge clk);
    chk("rst count", 96'(bus.decoder_count), 96'd0);
    chk("rst decoder", bus.decoder, 96'd0);
    chk("rst accept", 96'(bus.fetch_accept), 96'd1);
    chk("rst err", 96'(bus.consume_err), 96'd0);
    rst_n = 1'b1;
    step(0, 0, 0, 0, 0, 0);                 expect_st("reset", 0, 96'd0, 1, 0);
    step(1, 32'h44332211, 4, 0, 0, 0);      expect_st("fill0", 0, 96'd0, 1, 0);
    step(1, 32'h88776655, 4, 0, 0, 0);      expect_st("fill1", 4, 96'h44332211, 1, 0);
    step(1, 32'hCCBBAA99, 4, 0, 0, 0);      expect_st("fill2", 8, 96'h88776655_44332211, 1, 0);
    step(1, 32'hDDDDDDDD, 4, 1, 3, 0);      expect_st("full", 12, 96'hCCBBAA99_88776655_44332211, 0, 0);
    step(0, 0, 0, 1, 1, 0);                 expect_st("cons3", 9, 96'hCC_BBAA9988_77665544, 0, 0);
    step(1, 32'h0000F1F0, 2, 0, 0, 0);      expect_st("cons1", 8, 96'hCCBBAA99_88776655, 1, 0);
    step(0, 0, 0, 1, 5, 0);                 expect_st("app2", 10, 96'hF1F0_CCBBAA99_88776655, 0, 0);
    step(1, 32'h0000EEFF, 2, 1, 2, 0);      expect_st("cons5", 5, 96'hF1_F0CCBBAA, 1, 0);
    step(0, 0, 0, 1, 2, 0);                 expect_st("simul", 5, 96'hEE_FFF1F0CC, 1, 0);
    step(0, 0, 0, 1, 4, 0);                 expect_st("cons2", 3, 96'hEEFFF1, 1, 0);
    step(0, 0, 0, 1, 0, 0);                 expect_st("over", 3, 96'hEEFFF1, 1, 1);
    step(1, 32'h12345678, 0, 0, 0, 0);      expect_st("zero_len", 3, 96'hEEFFF1, 1, 1);
    step(1, 32'h9ABCDEF0, 5, 0, 0, 0);      expect_st("fc0", 3, 96'hEEFFF1, 1, 0);
    step(1, 32'h0A0B0C0D, 4, 0, 0, 0);      expect_st("fc5", 3, 96'hEEFFF1, 1, 0);
    step(1, 32'h000000E1, 1, 0, 0, 0);      expect_st("app4", 7, 96'h0A0B0C0D_EEFFF1, 1, 0);
    step(1, 32'h11111111, 4, 1, 2, 1);      expect_st("flush_pre", 8, 96'hE10A0B0C_0DEEFFF1, 0, 0);
    step(0, 0, 0, 1, 1, 0);                 expect_st("flushed", 0, 96'd0, 1, 0);
    step(0, 0, 0, 0, 0, 0);                 expect_st("empty_cons", 0, 96'd0, 1, 1);
    step(0, 0, 0, 0, 0, 0);                 expect_st("err_gone", 0, 96'd0, 1, 0);
`ifdef DECODE_WINDOW_STATS_EN
    chk("stat consumed", 96'(bus.stat_bytes_consumed), 96'd13);
    @(negedge clk);
    s = bus.stat_starve_cycles;
    repeat (5) step(0, 0, 0, 0, 0, 0);
    chk("stat starve", 96'(bus.stat_starve_cycles), 96'(s + 32'd5));
`endif
    step(1, 32'h44332211, 4, 0, 0, 0);      expect_st("refill", 0, 96'd0, 1, 0);
    step(1, 32'h88776655, 4, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    #2;
    chk("prefill count", 96'(bus.decoder_count), 96'd8);
    rst_n = 1'b0;
    #1;
    chk("async count", 96'(bus.decoder_count), 96'd0);
    chk("async decoder", bus.decoder, 96'd0);
    chk("async accept", 96'(bus.fetch_accept), 96'd1);
`ifdef DECODE_WINDOW_STATS_EN
    chk("async stat", 96'(bus.stat_bytes_consumed), 96'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    chk("queue drained", 96'(q.size()), 96'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
